// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: FSM encoding and parameter legality.
package mul_pkg;

  localparam logic [1:0] ENC_IDLE = 2'b00;
  localparam logic [1:0] ENC_RUN  = 2'b10;
  localparam logic [1:0] ENC_DONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_RUN  = ENC_RUN,
    ST_DONE = ENC_DONE
  } state_e;

  // STEP must be 1, 2 or 4 and divide an even WIDTH of at least 4.
  function automatic bit step_legal(input int width, input int step);
    return ((step == 1) || (step == 2) || (step == 4)) &&
           (width >= 4) && ((width % 2) == 0) && ((width % step) == 0);
  endfunction

endpackage

// File: rtl/mul_pp_step.sv
// Combinational partial product: sum of STEP shifted copies of the multiplicand,
// each gated by the corresponding multiplier bit.
module mul_pp_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [2*WIDTH-1:0] shift1_i,
  input  logic [STEP-1:0]    bits_i,
  output logic [2*WIDTH-1:0] pp_o
);

  always_comb begin
    pp_o = '0;
    for (int i = 0; i < STEP; i++) begin
      if (bits_i[i]) begin
        pp_o = pp_o + (shift1_i << i);
      end
    end
  end

endmodule

// File: rtl/mul_iter_n.sv
// Iterative shift-add multiplier: full 2*WIDTH-bit signed/unsigned product,
// STEP multiplier bits per cycle, start/annul/ready handshake.
module mul_iter_n
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_mul_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (!step_legal(WIDTH, STEP)) begin : g_bad_step
    $error("mul_iter_n: illegal WIDTH/STEP combination");
  end

  state_e               state_q;
  logic [2*WIDTH-1:0]   shift1_q;
  logic [WIDTH-1:0]     mult2_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;

  logic                 op1_neg_d;
  logic                 op2_neg_d;
  logic [WIDTH-1:0]     mag1_d;
  logic [WIDTH-1:0]     mag2_d;
  logic                 neg_d;
  logic [2*WIDTH-1:0]   pp_d;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   result_d;

  // The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  always_comb begin
    op1_neg_d = signed_mul_i & opdata1_i[WIDTH-1];
    op2_neg_d = signed_mul_i & opdata2_i[WIDTH-1];
    mag1_d    = op1_neg_d ? -opdata1_i : opdata1_i;
    mag2_d    = op2_neg_d ? -opdata2_i : opdata2_i;
    neg_d     = op1_neg_d ^ op2_neg_d;
    acc_d     = acc_q + pp_d;
    result_d  = neg_q ? -acc_q : acc_q;
  end

  mul_pp_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_pp (
    .shift1_i (shift1_q),
    .bits_i   (mult2_q[STEP-1:0]),
    .pp_o     (pp_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      shift1_q <= '0;
      mult2_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          result_q <= '0;
          ready_q  <= 1'b0;
          if (start_i && !annul_i) begin
            shift1_q <= {{WIDTH{1'b0}}, mag1_d};
            mult2_q  <= mag2_d;
            neg_q    <= neg_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (annul_i) begin
            state_q <= ST_IDLE;
          end else if (cnt_q != CNT_LAST) begin
            acc_q    <= acc_d;
            shift1_q <= shift1_q << STEP;
            mult2_q  <= mult2_q >> STEP;
            cnt_q    <= cnt_q + CNT_ONE;
          end else begin
            result_q <= result_d;
            ready_q  <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!start_i || annul_i) begin
            result_q <= '0;
            ready_q  <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          result_q <= '0;
          ready_q  <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_iter_n.sv
// Directed bench for mul_iter_n: one WIDTH=32/STEP=1 and one WIDTH=32/STEP=4 instance.
module tb_mul_iter_n;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_mul = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] res1, res4;
  logic        rdy1, rdy4, busy1, busy4;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_iter_n #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk          (clk),
    .rst          (rst),
    .signed_mul_i (signed_mul),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start1),
    .annul_i      (annul),
    .result_o     (res1),
    .ready_o      (rdy1),
    .busy_o       (busy1)
  );

  mul_iter_n #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk          (clk),
    .rst          (rst),
    .signed_mul_i (signed_mul),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start4),
    .annul_i      (annul),
    .result_o     (res4),
    .ready_o      (rdy4),
    .busy_o       (busy4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_of(input bit sel);
    return sel ? rdy4 : rdy1;
  endfunction

  function automatic logic [63:0] res_of(input bit sel);
    return sel ? res4 : res1;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? busy4 : busy1;
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) start4 = v;
    else     start1 = v;
  endtask

  // Drive a request and let it be taken on the next rising edge (E0).
  task automatic accept(input string tag, input bit sel, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_mul = sgn;
    op1 = a;
    op2 = b;
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    chk({tag, "_busy"}, 64'(busy_of(sel)), 64'd1);
  endtask

  // Count edges after E0 until ready_o rises, then check latency and product.
  task automatic wait_ready(input string tag, input bit sel, input int lat,
                            input logic [63:0] exp);
    int edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!rdy_of(sel) && edges < 200);
    chk({tag, "_lat"}, 64'(edges), 64'(lat));
    chk({tag, "_res"}, res_of(sel), exp);
  endtask

  task automatic release_req(input string tag, input bit sel);
    @(negedge clk);
    set_start(sel, 1'b0);
    @(posedge clk);
    #1;
    chk({tag, "_rdy_clr"}, 64'(rdy_of(sel)), 64'd0);
    chk({tag, "_res_clr"}, res_of(sel), 64'd0);
    chk({tag, "_idle"}, 64'(busy_of(sel)), 64'd0);
  endtask

  initial begin
    int seen;

    // Reset state
    #12;
    chk("rst_res1", res1, 64'd0);
    chk("rst_rdy1", 64'(rdy1), 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    chk("rst_busy4", 64'(busy4), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Unsigned full-scale, STEP=1
    accept("u_ff", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_ready("u_ff", 1'b0, 33, 64'hFFFF_FFFE_0000_0001);
    release_req("u_ff", 1'b0);

    // Signed, STEP=1
    accept("s_m3x7", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7);
    wait_ready("s_m3x7", 1'b0, 33, 64'hFFFF_FFFF_FFFF_FFEB);
    release_req("s_m3x7", 1'b0);

    accept("s_minxmin", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);
    wait_ready("s_minxmin", 1'b0, 33, 64'h4000_0000_0000_0000);
    release_req("s_minxmin", 1'b0);

    accept("s_minx1", 1'b0, 1'b1, 32'h8000_0000, 32'd1);
    wait_ready("s_minx1", 1'b0, 33, 64'hFFFF_FFFF_8000_0000);
    release_req("s_minx1", 1'b0);

    accept("s_0xm1", 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF);
    wait_ready("s_0xm1", 1'b0, 33, 64'd0);
    release_req("s_0xm1", 1'b0);

    // Unsigned, STEP=4
    accept("u4", 1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_ready("u4", 1'b1, 9, 64'h0B00_EA4E_242D_2080);
    release_req("u4", 1'b1);

    accept("s4_m3x7", 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd7);
    wait_ready("s4_m3x7", 1'b1, 9, 64'hFFFF_FFFF_FFFF_FFEB);
    release_req("s4_m3x7", 1'b1);

    // Annul on RUN cycle 10
    accept("ann", 1'b0, 1'b0, 32'd1000, 32'd1000);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    chk("ann_busy", 64'(busy1), 64'd0);
    chk("ann_rdy", 64'(rdy1), 64'd0);
    chk("ann_res", res1, 64'd0);
    @(negedge clk);
    annul = 1'b0;
    start1 = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (rdy1) seen++;
    end
    chk("ann_no_rdy", 64'(seen), 64'd0);
    accept("ann_6x7", 1'b0, 1'b0, 32'd6, 32'd7);
    wait_ready("ann_6x7", 1'b0, 33, 64'd42);
    release_req("ann_6x7", 1'b0);

    // Operands change after accept; result must use the latched values
    accept("lat", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    op1 = 32'd5;
    op2 = 32'hFFFF_FFFE;
    signed_mul = 1'b0;
    wait_ready("lat", 1'b0, 33, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("lat_hold_rdy", 64'(rdy1), 64'd1);
    chk("lat_hold_res", res1, 64'd1);
    release_req("lat", 1'b0);

    // Asynchronous reset mid-RUN
    accept("arst", 1'b0, 1'b0, 32'hFFFF, 32'hFFFF);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy1), 64'd0);
    chk("arst_rdy", 64'(rdy1), 64'd0);
    chk("arst_res", res1, 64'd0);
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (rdy1) seen++;
    end
    chk("arst_no_rdy", 64'(seen), 64'd0);
    accept("arst_2x3", 1'b0, 1'b0, 32'd2, 32'd3);
    wait_ready("arst_2x3", 1'b0, 33, 64'd6);
    release_req("arst_2x3", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_iter_n.md
# mul_iter_n

Parametrised iterative shift-add multiplier, successor to the fixed 32-bit radix-2 unit in the execute stage. It computes a full 2×WIDTH-bit signed or unsigned product in WIDTH/STEP accumulate cycles. It uses the same start/annul/ready handshake the EX stage already drives for MULT/MULTU. New relative to the 32-bit unit:
- width and bits-per-cycle are parameters;
- operand signs are latched at accept;
- a busy flag is exported for stall logic.

## Interface
- WIDTH, 32, operand width; even, ≥ 4
- STEP, 1, multiplier bits consumed per cycle; one of 1, 2, 4; must divide WIDTH
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- signed_mul_i  in  1  1 = two's-complement operands, 0 = unsigned
- opdata1_i  in  WIDTH  multiplicand
- opdata2_i  in  WIDTH  multiplier
- start_i  in  1  request; held high until result consumed
- annul_i  in  1  abort (flush/exception)
- result_o  out  2*WIDTH  product
- ready_o  out  1  result valid
- busy_o  out  1  high whenever state ≠ IDLE

## Operation
- Constant: N = WIDTH/STEP.
- States: IDLE, RUN, DONE.
- **IDLE**
  - If start_i=1 and annul_i=0:
    - latch |opdata1_i| into a 2W-bit shift register and |opdata2_i| into a W-bit shift register (magnitudes only when signed_mul_i=1 and MSB=1);
    - latch neg = signed_mul_i & (op1[W-1] ^ op2[W-1]);
    - acc = 0, cnt = 0;
    - next state RUN.
  - Otherwise: ready_o = 0, result_o = 0.
- **RUN**
  - annul_i = 1 → IDLE. result_o and ready_o stay 0; acc is discarded.
  - cnt < N:
    - acc += shift1 × mult2[STEP-1:0];
    - shift1 <<= STEP; mult2 >>= STEP;
    - cnt++.
  - cnt = N:
    - result_o = neg ? (~acc + 1) : acc, mod 2^(2W);
    - ready_o = 1;
    - next state DONE.
- **DONE**
  - Hold result_o and ready_o while start_i = 1.
  - start_i = 0 or annul_i = 1 → IDLE, with ready_o = 0 and result_o = 0 on that edge.
- Inputs are sampled only at the accept edge. Operand or signed_mul_i changes during RUN/DONE have no effect.
- Most-negative operand: magnitude 2^(W-1) fits in W unsigned bits, so no overflow. −2^(W-1) × −2^(W-1) = 2^(2W-2).
- Zero operand with neg = 1 produces 0.

## Timing
- Async reset (rst = 0):
  - state = IDLE;
  - result_o = 0, ready_o = 0, busy_o = 0;
  - acc, shift registers and cnt = 0.
- Reset mid-RUN or mid-DONE aborts immediately. No ready_o pulse follows.
- Latency: start accepted at edge E0 → ready_o and result_o valid after edge E0+N+1.
  - WIDTH = 32, STEP = 1: 33 cycles.
  - WIDTH = 32, STEP = 4: 9 cycles.
- busy_o rises after E0 and falls on the edge that returns the unit to IDLE.
- Back-to-back operation: start_i must drop for at least one edge in DONE. A new accept is possible on the next edge after returning to IDLE.
- start_i and annul_i both high in IDLE: request not accepted.

## Structure
- Shared package mul_pkg holds:
  - state encoding localparams (IDLE = 2'b00, RUN = 2'b10, DONE = 2'b11);
  - the legal-STEP check.
- Sub-module mul_pp_step: combinational partial-product generator.
  - Inputs: shift1 (2W) and mult2[STEP-1:0].
  - Output: sum of STEP shifted copies, gated by each bit.
- All registers and the FSM live in mul_iter_n.

## Test plan
- Unsigned, W32/S1: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE00000001. ready_o high exactly 33 edges after accept.
- Signed, W32/S1:
  - −3 × 7 → 0xFFFFFFFFFFFFFFEB;
  - 0x80000000 × 0x80000000 → 0x4000000000000000;
  - 0x80000000 × 1 → 0xFFFFFFFF80000000.
- Unsigned, W32/S4: 0x12345678 × 0x9ABCDEF0 → 0x0B00EA4E242D2080. ready_o 9 edges after accept.
- annul_i pulsed on RUN cycle 10:
  - unit returns to IDLE, ready_o never rises, busy_o falls;
  - a following 6 × 7 request → 42.
- Signed −1 × −1 accepted, then operands changed to 5 and −2 on the next cycle → result 1. Result and ready_o stay held until start_i drops, then both clear.
- rst driven low asynchronously mid-RUN:
  - all outputs 0 before the next clock edge;
  - after release, a new 2 × 3 request → 6.
